// File: rtl/excp_commit_ctrl_if.sv
// Redirect handshake between the commit-stage exception sequencer and fetch.
interface excp_commit_ctrl_if;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        redirect_ready_i;

   modport master (output redirect_valid_o, output redirect_pc_o, input redirect_ready_i);
   modport slave  (input redirect_valid_o, input redirect_pc_o, output redirect_ready_i);
endinterface

// File: rtl/excp_commit_ctrl.sv
// Commit-stage exception/ERTN sequencer: picks the oldest trapping event, pulses the
// CSR trap/ERTN update, holds a multi-cycle flush, then redirects fetch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accepting commits, evaluating lanes for interrupt/exception/ERTN
// FLUSH    | flush_o high, down-counter running to terminal count 0
// REDIRECT | redirect_valid_o held with a stable target until fetch accepts
module excp_commit_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int LANES        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LANES-1:0]      commit_valid_i,
   input  logic [LANES-1:0]      excp_trigger_i,
   input  logic [6*LANES-1:0]    ecode_i,
   input  logic [9*LANES-1:0]    esubcode_i,
   input  logic [32*LANES-1:0]   bad_va_i,
   input  logic [32*LANES-1:0]   pc_i,
   input  logic [LANES-1:0]      ertn_i,
   input  logic                  int_pending_i,
   input  logic [31:0]           eentry_i,
   input  logic [31:0]           era_i,
   excp_commit_ctrl_if.master    redir,
   output logic                  commit_stall_o,
   output logic [LANES-1:0]      lane_kill_o,
   output logic                  trap_we_o,
   output logic [5:0]            trap_ecode_o,
   output logic [8:0]            trap_esubcode_o,
   output logic [31:0]           trap_era_o,
   output logic                  badv_we_o,
   output logic [31:0]           badv_o,
   output logic                  ertn_we_o,
   output logic                  flush_o
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] redir_pc_q;

   logic             sel_hit, sel_excp, chain, take, badv_code;
   logic [5:0]       sel_ecode;
   logic [8:0]       sel_esub;
   logic [31:0]      sel_pc, sel_badva;
   logic [LANES-1:0] kill;

   // Lane k is only eligible while every older lane is also committing.
   always_comb begin
      sel_hit   = 1'b0;
      sel_excp  = 1'b0;
      sel_ecode = '0;
      sel_esub  = '0;
      sel_pc    = '0;
      sel_badva = '0;
      kill      = '0;
      chain     = 1'b1;
      if (int_pending_i && commit_valid_i[0]) begin
         sel_hit  = 1'b1;
         sel_excp = 1'b1;
         sel_pc   = pc_i[31:0];
         kill     = '1;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            chain = chain & commit_valid_i[k];
            if (sel_hit) begin
               kill[k] = 1'b1;
            end else if (chain && (excp_trigger_i[k] || ertn_i[k])) begin
               sel_hit   = 1'b1;
               sel_excp  = excp_trigger_i[k];
               kill[k]   = excp_trigger_i[k];
               sel_ecode = ecode_i[6*k +: 6];
               sel_esub  = esubcode_i[9*k +: 9];
               sel_pc    = pc_i[32*k +: 32];
               sel_badva = bad_va_i[32*k +: 32];
            end
         end
      end
   end

   assign take      = (state == IDLE) && sel_hit;
   assign badv_code = ((sel_ecode >= 6'h01) && (sel_ecode <= 6'h09)) || (sel_ecode == 6'h3F);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (take) begin
               state_nxt = FLUSH;
               cnt_nxt   = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (cnt == 4'd0) state_nxt = REDIRECT;
            else             cnt_nxt   = cnt - 4'd1;
         end
         REDIRECT: begin
            if (redir.redirect_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         trap_we_o       <= 1'b0;
         ertn_we_o       <= 1'b0;
         badv_we_o       <= 1'b0;
         trap_ecode_o    <= '0;
         trap_esubcode_o <= '0;
         trap_era_o      <= '0;
         badv_o          <= '0;
         redir_pc_q      <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         trap_we_o <= take && sel_excp;
         ertn_we_o <= take && !sel_excp;
         badv_we_o <= take && sel_excp && badv_code;
         if (take && sel_excp) begin
            trap_ecode_o    <= sel_ecode;
            trap_esubcode_o <= sel_esub;
            trap_era_o      <= sel_pc;
         end
         if (take && sel_excp && badv_code) badv_o <= sel_badva;
         if (take) redir_pc_q <= sel_excp ? eentry_i : era_i;
      end
   end

   assign lane_kill_o            = (state == IDLE) ? kill : '0;
   assign commit_stall_o         = (state != IDLE);
   assign flush_o                = (state == FLUSH);
   assign redir.redirect_valid_o = (state == REDIRECT);
   assign redir.redirect_pc_o    = redir_pc_q;

endmodule

// File: doc/excp_commit_ctrl.md
Name: excp_commit_ctrl

Overview:
- Commit-stage exception/ERTN sequencer for the dual-issue pipeline.
- Takes per-lane exception info produced by the decode-stage exception detector, plus interrupt-pending from CSR.
- Selects the oldest trapping event and issues one atomic CSR trap-update strobe.
- Drives a multi-cycle pipeline flush, then hands a redirect PC to fetch over a valid/ready handshake.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o is held high (1..15).
- LANES, 2, commit lanes; lane 0 is always the older instruction.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- commit_valid_i  in  LANES  lane holds a committing instruction
- excp_trigger_i  in  LANES  lane raised an exception
- ecode_i  in  6*LANES  exception primary code per lane
- esubcode_i  in  9*LANES  exception subcode per lane
- bad_va_i  in  32*LANES  faulting virtual address per lane
- pc_i  in  32*LANES  lane PC
- ertn_i  in  LANES  lane is an ERTN instruction
- int_pending_i  in  1  CSR reports an enabled, pending interrupt
- eentry_i  in  32  CSR EENTRY
- era_i  in  32  CSR ERA
- redirect_ready_i  in  1  fetch accepts redirect
- commit_stall_o  out  1  blocks further commit while busy
- lane_kill_o  out  LANES  suppress lane's architectural writeback this cycle
- trap_we_o  out  1  one-cycle CSR trap update (CRMD to PRMD save, ESTAT, ERA)
- trap_ecode_o  out  6  ESTAT.Ecode
- trap_esubcode_o  out  9  ESTAT.EsubCode
- trap_era_o  out  32  ERA value
- badv_we_o  out  1  BADV write enable
- badv_o  out  32  BADV value
- ertn_we_o  out  1  one-cycle PRMD to CRMD restore
- flush_o  out  1  flush all younger pipeline state
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, counter 0, all outputs 0.
- States: IDLE, FLUSH, REDIRECT.

Event selection (IDLE only, combinational on the inputs):
- Interrupt: int_pending_i && commit_valid_i[0]. Ecode 0x0, subcode 0, ERA = pc_i[0], lane_kill = all lanes.
- Else, the lowest lane k with commit_valid_i[k] && (excp_trigger_i[k] || ertn_i[k]).
- Lanes above k are killed.
- Lane k itself is killed if it has an exception; it is not killed for ERTN.
- If excp_trigger_i[k] and ertn_i[k] are both set, the exception wins.
- Lane 1 is never considered when lane 0 is invalid.

Actions in the event cycle (registered outputs, visible the cycle after the event):
- Exception: trap_we_o=1 for exactly one cycle.
  - trap_ecode_o/trap_esubcode_o come from lane k; trap_era_o = pc_i[k].
  - badv_we_o=1 only when ecode is 0x1-0x9 or 0x3F, with badv_o = bad_va_i[k]; otherwise badv_we_o=0.
  - Target = eentry_i.
- ERTN: ertn_we_o=1 for one cycle; target = era_i, sampled in the event cycle.
- Either event: flush_o=1, counter loaded with FLUSH_CYCLES-1, go to FLUSH.
- lane_kill_o is combinational, valid in the event cycle itself.

State behaviour:
- FLUSH: flush_o=1, counter decrements each cycle. At 0 go to REDIRECT with redirect_valid_o=1.
- REDIRECT: redirect_valid_o and redirect_pc_o stay stable until redirect_ready_i. On the handshake cycle go to IDLE, and redirect_valid_o drops the next cycle.
- commit_stall_o=1 in FLUSH and REDIRECT.
- In FLUSH and REDIRECT, inputs are ignored and new events are not accepted. int_pending_i is re-evaluated only once back in IDLE.
- FLUSH_CYCLES=1: exactly one cycle of flush_o.
- Reset mid-FLUSH/REDIRECT: abort to IDLE next cycle. No strobe is re-issued.

Test Plan:
- Lane0 valid, excp_trigger, ecode 0x0B, pc 0x1C000100; eentry 0x1C008000 -> one cycle later trap_we_o=1, ecode 0x0B, era 0x1C000100, badv_we_o=0, lane_kill=2'b11; flush_o high 2 cycles, then redirect_pc_o=0x1C008000 until ready.
- Lane0 clean, lane1 ecode 0x09 (ALE), bad_va 0x00000003 -> lane_kill=2'b10, badv_we_o=1, badv_o=0x00000003, era=pc_i[1].
- Lane0 ERTN, era_i 0x1C000234 -> ertn_we_o=1, trap_we_o=0, lane_kill[0]=0, lane_kill[1]=1, redirect_pc_o=0x1C000234.
- int_pending_i with lane1 ecode 0x0D -> ecode 0x00, era=pc_i[0], no BADV write.
- redirect_ready_i held low 5 cycles -> redirect_valid_o and redirect_pc_o stable, commit_stall_o=1 throughout; new exception inputs are ignored.
- rst_n low during FLUSH -> next cycle all outputs 0, state IDLE; a new event is accepted normally afterwards.
